// File: rtl/vdic_rsp_deserializer_pkg.sv
// Shared types for the serial response deserializer: word format constants,
// receiver FSM states, status encoding and the decoded-frame record.
package vdic_rsp_deserializer_pkg;

  localparam int   WORD_BITS = 10;
  localparam logic TYPE_CMD  = 1'b1;
  localparam logic TYPE_DATA = 1'b0;

  // Upper bound on N_DATA_WORDS; rsp_t carries data right-aligned in this width.
  localparam int MAX_DATA_WORDS = 4;
  localparam int RSP_DATA_W     = 8 * MAX_DATA_WORDS;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_RECV = 2'd1,
    RX_DONE = 2'd2
  } rx_state_t;

  typedef enum logic [7:0] {
    S_NO_ERROR             = 8'b0000_0000,
    S_MISSING_DATA         = 8'b0000_0001,
    S_DATA_STACK_OVERFLOW  = 8'b0000_0010,
    S_OUTPUT_OVERFLOW      = 8'b0000_0100,
    S_DATA_PARITY_ERROR    = 8'b0010_0000,
    S_COMMAND_PARITY_ERROR = 8'b0100_0000,
    S_INVALID_COMMAND      = 8'b1000_0000
  } stat_t;

  typedef struct packed {
    logic [7:0]            status;
    logic [RSP_DATA_W-1:0] data;
    logic                  err_parity;
    logic                  err_type;
    logic                  err_frame;
  } rsp_t;

  // Even parity over the whole word, parity bit included.
  function automatic logic even_parity_ok(input logic [WORD_BITS-1:0] word);
    return ~(^word);
  endfunction

endpackage

// File: rtl/vdic_word_rx.sv
// 10-bit MSB-first word shifter with bit counter; word_done pulses for one
// cycle while the shifter holds a complete word.
module vdic_word_rx
  import vdic_rsp_deserializer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       shift_en,
  input  logic       din,
  output logic       word_done,
  output logic       word_type,
  output logic [7:0] word_byte,
  output logic       parity_ok
);

  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 word_done_q, word_done_d;

  always_comb begin
    // NOTE: every _d gets its default before any branch so no latch is inferred.
    shift_d     = shift_q;
    bit_cnt_d   = '0;
    word_done_d = 1'b0;
    // The counter only advances over contiguous valid bits; any gap restarts it.
    if (shift_en) begin
      shift_d = {shift_q[WORD_BITS-2:0], din};
      if (bit_cnt_q == 4'(WORD_BITS - 1)) begin
        word_done_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      word_done_q <= word_done_d;
    end
  end

  assign word_done = word_done_q;
  assign word_type = shift_q[WORD_BITS-1];
  assign word_byte = shift_q[WORD_BITS-2:1];
  assign parity_ok = even_parity_ok(shift_q);

endmodule

// File: rtl/vdic_rsp_deserializer.sv
// Reassembles a status word plus N_DATA_WORDS data words from the serial
// response line and presents the checked frame on a valid/ready register.
module vdic_rsp_deserializer
  import vdic_rsp_deserializer_pkg::*;
#(
  parameter int N_DATA_WORDS = 2,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dout,
  input  logic                    dout_valid,
  output logic [7:0]              rsp_status,
  output logic [8*N_DATA_WORDS-1:0] rsp_data,
  output logic                    err_parity,
  output logic                    err_type,
  output logic                    err_frame,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    overrun
);

  localparam int DATA_W = 8 * N_DATA_WORDS;
  localparam int WCNT_W = $clog2(N_DATA_WORDS + 1);

  rx_state_t         state_q, state_d;
  logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
  rsp_t              frame_q, frame_d;
  rsp_t              rsp_q, rsp_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              overrun_q, overrun_d;
  logic              block_q, block_d;

  logic       word_done, word_type, parity_ok;
  logic [7:0] word_byte;
  logic       start, last_word, shift_en, accept;

  vdic_word_rx u_word_rx (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .din       (dout),
    .word_done (word_done),
    .word_type (word_type),
    .word_byte (word_byte),
    .parity_ok (parity_ok)
  );

  // block_q keeps an overlong or interrupted frame from being mistaken for a new one.
  assign start     = (state_q == RX_IDLE) && dout_valid && !block_q;
  assign last_word = word_done && (word_cnt_q == WCNT_W'(N_DATA_WORDS));
  assign shift_en  = start || ((state_q == RX_RECV) && dout_valid && !last_word);
  assign accept    = rsp_valid_q && rsp_ready;

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    frame_d     = frame_q;
    rsp_d       = rsp_q;
    rsp_valid_d = rsp_valid_q && !accept;
    overrun_d   = overrun_q;
    block_d     = block_q && dout_valid;

    unique case (state_q)
      RX_IDLE: begin
        if (start) begin
          state_d    = RX_RECV;
          word_cnt_d = '0;
          frame_d    = '0;
        end
      end

      RX_RECV: begin
        if (word_done) begin
          word_cnt_d = word_cnt_q + WCNT_W'(1);
          if (word_cnt_q == '0) begin
            frame_d.status = word_byte;
            if (word_type != TYPE_CMD) frame_d.err_type = 1'b1;
          end else begin
            // First data word lands in the most significant byte.
            for (int i = 0; i < N_DATA_WORDS; i++) begin
              if (word_cnt_q == WCNT_W'(i + 1)) frame_d.data[(N_DATA_WORDS-1-i)*8 +: 8] = word_byte;
            end
            if (word_type != TYPE_DATA) frame_d.err_type = 1'b1;
          end
          if (CHECK_PARITY && !parity_ok) frame_d.err_parity = 1'b1;
        end

        if (last_word) begin
          state_d = RX_DONE;
          if (dout_valid) begin
            frame_d.err_frame = 1'b1;
            block_d           = 1'b1;
          end
        end else if (!dout_valid) begin
          state_d           = RX_DONE;
          frame_d.err_frame = 1'b1;
        end
      end

      RX_DONE: begin
        state_d = RX_IDLE;
        if (dout_valid) block_d = 1'b1;
        if (!rsp_valid_q || rsp_ready) begin
          rsp_d       = frame_q;
          rsp_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end

      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RX_IDLE;
      word_cnt_q  <= '0;
      frame_q     <= '0;
      rsp_q       <= '0;
      rsp_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      // A frame in flight across reset must finish before the next one counts.
      block_q     <= dout_valid;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      frame_q     <= frame_d;
      rsp_q       <= rsp_d;
      rsp_valid_q <= rsp_valid_d;
      overrun_q   <= overrun_d;
      block_q     <= block_d;
    end
  end

  // Bits of rsp_q.data above DATA_W are never written and stay zero.
  logic unused_data;
  assign unused_data = ^rsp_q.data;

  assign rsp_status = rsp_q.status;
  assign rsp_data   = rsp_q.data[DATA_W-1:0];
  assign err_parity = rsp_q.err_parity;
  assign err_type   = rsp_q.err_type;
  assign err_frame  = rsp_q.err_frame;
  assign rsp_valid  = rsp_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/vdic_rsp_deserializer.md
Name: vdic_rsp_deserializer

Overview:
- Downstream receiver for the DUT serial response path. Consumes `dout`/`dout_valid` and reassembles one response frame: a status word followed by two data words, each 10 bits.
- Checks per-word parity, word type and framing, then presents status, a 16-bit result and error flags on a valid/ready interface.
- Serves as the RTL counterpart of the bench's response reader. Feeds the scoreboard or a host register block.

Parameters:
- N_DATA_WORDS, 2, data words following the status word; result width = 8*N_DATA_WORDS.
- CHECK_PARITY, 1, 1 = parity errors flagged; 0 = parity bit ignored (err_parity held 0).

Ports:
- clk  in  1  single system clock; all sampling on posedge.
- rst  in  1  reset, synchronous, active-high.
- dout  in  1  serial response bit from the DUT.
- dout_valid  in  1  high for the whole frame, contiguous.
- rsp_status  out  8  status byte (stat_t encoding).
- rsp_data  out  8*N_DATA_WORDS  result, first data word in MSBs.
- err_parity  out  1  at least one word had a parity mismatch.
- err_type  out  1  word type bit wrong (status must be 1, data must be 0).
- err_frame  out  1  dout_valid dropped mid-frame or exceeded the frame length.
- rsp_valid  out  1  output register holds an unconsumed frame.
- rsp_ready  in  1  consumer accepts the frame when rsp_valid & rsp_ready.
- overrun  out  1  sticky: a frame completed while rsp_valid was still high; cleared only by rst.

Behaviour:
- Word format, MSB first, one bit per posedge: type, d[7:0], parity. Parity is even over all 10 bits: parity == ^{type,d}.
- Reset (rst=1 at posedge): FSM=IDLE, counters 0, all outputs 0, overrun 0.
- IDLE:
  - On a posedge with dout_valid=1: sample bit 0 of word 0, bit_cnt=1, go to RECV.
- RECV:
  - On each posedge with dout_valid=1: shift dout in and advance bit_cnt 0..9.
  - At bit_cnt=9: latch the word, check type and parity, set bit_cnt=0, increment word_cnt.
  - After word N_DATA_WORDS is latched: go to DONE.
- Framing errors:
  - dout_valid=0 while in RECV with any bit received: abort and go to DONE with err_frame=1. Already-latched words are kept; missing bytes read 0.
  - Also set err_frame=1 if dout_valid is still 1 on the first posedge after the final parity bit. The extra bits are ignored until dout_valid falls; only then may a new frame start.
- DONE (one cycle): load the output register, set rsp_valid=1, return to IDLE.
- Latency: rsp_valid rises on the 2nd posedge after the posedge that sampled the last parity bit.
- Handshake:
  - rsp_valid and the data/error outputs are held stable until rsp_valid & rsp_ready.
  - rsp_valid falls on the posedge after acceptance unless a new frame loads on that same edge. In that case rsp_valid stays 1 with the new contents (acceptance and load coincide, no overrun).
- Overrun: DONE while rsp_valid=1 and rsp_ready=0 drops the new frame, keeps the old one, and sets overrun=1.
- Reception continues regardless of rsp_ready; there is no backpressure on the serial side.
- rst mid-frame discards partial state on that edge. Bits arriving after rst falls are treated as a new frame only from the next rising of dout_valid.
- Error flags are per frame (OR over its words), except overrun.

Decomposition:
- Shared package gets:
  - WORD_BITS=10, TYPE_CMD=1'b1, TYPE_DATA=1'b0.
  - The rx FSM state enum rx_state_t {RX_IDLE, RX_RECV, RX_DONE}.
  - An rsp_t struct {status, data, err_parity, err_type, err_frame}.
  - stat_t reused as-is.
- One natural sub-module: vdic_word_rx, a 10-bit shifter plus bit counter that emits word_done, type, byte and parity_ok. The top holds the word counter, FSM and output register.

Test Plan:
- Frame status 8'h20 (type1, par0), 8'h12 (type0, par0), 8'h34 (type0, par1), rsp_ready=1 -> rsp_status=8'h20, rsp_data=16'h1234, all err=0, rsp_valid high exactly 1 cycle.
- Same frame with the parity bit of word 2 inverted -> rsp_data=16'h1234, err_parity=1; with CHECK_PARITY=0 -> err_parity=0.
- Status word sent with type bit 0 -> err_type=1, data still 16'h1234.
- dout_valid dropped after 5 bits of word 1 -> err_frame=1, rsp_status=8'h20, rsp_data=16'h0000.
- Two back-to-back frames (8'h20/16'h1234 then 8'h00/16'hBEEF), rsp_ready=0 -> first frame held, overrun=1. Then raise rsp_ready -> 16'h1234 accepted; a third frame is received normally.
- rst pulsed at bit 17 of a frame -> outputs 0. The next full frame 8'h00/16'h00FF decodes correctly with no error.
